// File: rtl/md_pkg.sv
// Shared definitions for the parametrised multiply/divide unit: op codes,
// op-class helpers and counter sizing.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_acc_op(logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  // Accumulate codes only count as multi-cycle work when they are built in.
  function automatic logic is_mult_class(logic [3:0] op, logic en_acc);
    return (op == MD_MULT) || (op == MD_MULTU) || (en_acc && is_acc_op(op));
  endfunction

  function automatic logic is_div_class(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic int cnt_w(int mult_lat, int div_lat);
    int m;
    m = (mult_lat > div_lat) ? mult_lat : div_lat;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result generator: produces the {hi,lo} an op will commit,
// plus whether it commits at all (divide by zero and disabled ops do not).
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int EN_ACC = 1
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_wr
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             msgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic             dsgn, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, q, r, quo, rem;

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both forms.
  assign msgn  = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
  assign ext_a = msgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b = msgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi, lo};

  // Divide on magnitudes, then restore signs; a zero divisor is steered to 1
  // so the divider never sees it (the result is discarded anyway).
  assign dsgn  = (op == MD_DIV);
  assign neg_a = dsgn & a[WIDTH-1];
  assign neg_b = dsgn & b[WIDTH-1];
  assign mag_a = neg_a ? (~a + 1'b1) : a;
  assign mag_b = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : (neg_b ? (~b + 1'b1) : b);
  assign q     = mag_a / mag_b;
  assign r     = mag_a % mag_b;

  always_comb begin
    quo = (neg_a ^ neg_b) ? (~q + 1'b1) : q;
    rem = neg_a ? (~r + 1'b1) : r;
    if (dsgn && (a == MIN_NEG) && (b == '1)) begin
      quo = MIN_NEG;
      rem = '0;
    end
  end

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_wr = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      MD_MADD, MD_MADDU: begin
        {res_hi, res_lo} = acc + prod;
        res_wr = (EN_ACC != 0);
      end
      MD_MSUB, MD_MSUBU: begin
        {res_hi, res_lo} = acc - prod;
        res_wr = (EN_ACC != 0);
      end
      MD_DIV, MD_DIVU: begin
        res_hi = rem;
        res_lo = quo;
        res_wr = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_param.sv
// E-stage multiply/divide unit: owns HI/LO, models configurable op latency,
// and supports accumulate ops, flush and overrun reporting.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int EN_ACC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overrun
);

  localparam int CW = cnt_w(MULT_LAT, DIV_LAT);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  md_state_e        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_wr;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;
  logic             accept, is_mul, is_div, done;

  md_arith #(.WIDTH(WIDTH), .EN_ACC(EN_ACC)) u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_wr (res_wr)
  );

  // flush wins over start, so a flushed request is never accepted.
  assign accept = start && !flush && (state == S_IDLE);
  assign is_mul = is_mult_class(op, EN_ACC != 0);
  assign is_div = is_div_class(op);
  assign done   = (state == S_BUSY) && !flush && (cnt == '0);
  assign busy   = (state == S_BUSY);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && (is_mul || is_div)) state_nxt = S_BUSY;
      S_BUSY: if (flush || (cnt == '0))         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= start && !flush && (state == S_BUSY);
      if (accept) begin
        if (is_mul || is_div) begin
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          pend_wr <= res_wr;
          cnt     <= is_div ? DIV_CNT : MULT_CNT;
        end else if (op == MD_MTHI) begin
          hi <= a;
        end else if (op == MD_MTLO) begin
          lo <= a;
        end
      end
      if (done) begin
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else if ((state == S_BUSY) && !flush) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param with hand-computed expected HI/LO values.
module tb_md_unit_param;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, overrun;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  md_unit_param #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10), .EN_ACC(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    start = 1'b1; op = o; a = xa; b = xb;
    step();
    start = 1'b0; op = MD_NOP;
  endtask

  // Counts cycles with busy high, starting at the cycle just after accept.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic load(input logic [W-1:0] h, input logic [W-1:0] l);
    issue(MD_MTHI, h, '0);
    issue(MD_MTLO, l, '0);
  endtask

  int n;

  initial begin
    // reset
    step(); step();
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    step();

    // mult -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy0", busy, 1);
    chk("mult_hold", {hi, lo}, 64'h0);
    busy_len(n);
    chk("mult_lat", n, 5);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // mthi/mtlo then divu by zero leaves HI/LO untouched
    issue(MD_MTHI, 32'h11, '0);
    chk("mthi_busy", busy, 0); chk("mthi_hi", hi, 32'h11);
    issue(MD_MTLO, 32'h22, '0);
    chk("mtlo_lo", lo, 32'h22);
    issue(MD_DIVU, 32'd7, 32'd0);
    busy_len(n);
    chk("divz_lat", n, 10);
    chk("divz_res", {hi, lo}, {32'h11, 32'h22});

    // signed divide overflow and truncation
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    chk("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    chk("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(MD_DIVU, 32'd100, 32'd7);
    busy_len(n);
    chk("divu", {hi, lo}, {32'd2, 32'd14});

    // accumulate ops
    load(32'h0, 32'hFFFF_FFFF);
    issue(MD_MADD, 32'd1, 32'd1);
    busy_len(n);
    chk("madd_lat", n, 5);
    chk("madd", {hi, lo}, {32'h1, 32'h0});
    load(32'h0, 32'h0);
    issue(MD_MSUBU, 32'd1, 32'd1);
    busy_len(n);
    chk("msubu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(MD_MSUB, 32'hFFFF_FFFF, 32'd2);
    busy_len(n);
    chk("msub", {hi, lo}, 64'h1);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_len(n);
    chk("multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // flush in 3rd busy cycle, with a colliding start
    load(32'h0, 32'h1);
    issue(MD_MULT, 32'd5, 32'd6);
    step(); step();
    chk("fl_busy3", busy, 1);
    flush = 1'b1; start = 1'b1; op = MD_MULT; a = 32'd9; b = 32'd9;
    step();
    flush = 1'b0; start = 1'b0; op = MD_NOP;
    chk("fl_busy", busy, 0); chk("fl_ovr", overrun, 0);
    chk("fl_hold", {hi, lo}, 64'h1);
    step(); step(); step(); step(); step();
    chk("fl_after", {busy, hi, lo}, {1'b0, 64'h1});

    // flush while idle drops a same-cycle start
    flush = 1'b1; start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
    step();
    flush = 1'b0; start = 1'b0; op = MD_NOP;
    chk("fl_idle", {busy, hi}, {1'b0, 32'h0});

    // start while busy: one-cycle overrun, original result on time
    issue(MD_MULT, 32'd3, 32'd4);
    start = 1'b1; op = MD_MTLO; a = 32'h55;
    step();
    start = 1'b0; op = MD_NOP;
    chk("ovr_pulse", overrun, 1);
    step();
    chk("ovr_clear", overrun, 0);
    busy_len(n);
    chk("ovr_lat", n, 3);
    chk("ovr_res", {hi, lo}, {32'h0, 32'd12});

    // undefined op is a no-op
    issue(4'd15, 32'd1, 32'd1);
    chk("undef", {busy, hi, lo}, {1'b0, 32'h0, 32'd12});

    // reset mid-divide
    issue(MD_MTHI, 32'h99, '0);
    issue(MD_DIV, 32'd100, 32'd7);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_mid", {busy, overrun, hi, lo}, 66'h0);
    reset = 1'b1;
    step(); step();
    chk("rst_stay", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
